// File: rtl/sha2_pkg.sv
// Shared types and constants for the SHA-2 message padder.
package sha2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PAD,
        EMIT,
        XTRA
    } padder_state_e;

    localparam logic [7:0] PAD_BYTE = 8'h80;

    // Length field width in bits for a given block width (64 for 512b blocks, 128 for 1024b blocks).
    function automatic int unsigned len_width(input int unsigned block_width);
        return block_width / 8;
    endfunction

endpackage

// File: rtl/sha2_word_pad.sv
// Masks the final message word to its valid bytes and inserts the 0x80 pad byte after them.
module sha2_word_pad
    import sha2_pkg::*;
#(
    parameter  int unsigned DataWidth = 64,
    localparam int unsigned DataBytes = DataWidth / 8,
    localparam int unsigned BytesW    = $clog2(DataBytes + 1)
) (
    input  logic [DataWidth-1:0] word_i,
    input  logic [BytesW-1:0]    bytes_i,
    output logic [DataWidth-1:0] word_c,
    output logic                 pad_fit_c
);

    // Byte 0 sits in the MSBs; keep valid bytes, drop 0x80 right after them, zero the rest.
    always_comb begin
        word_c    = '0;
        pad_fit_c = (bytes_i < BytesW'(DataBytes));
        for (int b = 0; b < int'(DataBytes); b++) begin
            if (BytesW'(b) < bytes_i) begin
                word_c[DataWidth-1-8*b -: 8] = word_i[DataWidth-1-8*b -: 8];
            end else if (BytesW'(b) == bytes_i) begin
                word_c[DataWidth-1-8*b -: 8] = PAD_BYTE;
            end
        end
    end

endmodule

// File: rtl/sha2_padder.sv
// SHA-2 message padder: collects words into blocks, appends 0x80/zeros/length, hands blocks to the core.
module sha2_padder
    import sha2_pkg::*;
#(
    parameter  int unsigned DataWidth   = 64,
    parameter  int unsigned BlockWidth  = 1024,
    localparam int unsigned LenWidth    = len_width(BlockWidth),
    localparam int unsigned DataBytes   = DataWidth / 8,
    localparam int unsigned WordsPerBlk = BlockWidth / DataWidth,
    localparam int unsigned BlockBytes  = BlockWidth / 8,
    localparam int unsigned LenBytes    = LenWidth / 8,
    localparam int unsigned BytesW      = $clog2(DataBytes + 1),
    localparam int unsigned IdxW        = $clog2(WordsPerBlk)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DataWidth-1:0]  in_data_i,
    input  logic                  in_last_i,
    input  logic [BytesW-1:0]     in_bytes_i,
    output logic [BlockWidth-1:0] block_o,
    output logic                  block_valid_o,
    input  logic                  block_ready_i,
    output logic                  block_last_o,
    output logic                  busy_o
);

    padder_state_e         state_q, state_d;
    logic [BlockWidth-1:0] buf_q, buf_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [LenWidth-1:0]   len_q, len_d;
    logic [BytesW-1:0]     bytes_q, bytes_d;
    logic                  pad_fit_q, pad_fit_d;
    logic                  xtra_q, xtra_d;
    logic                  xtra_pad_q, xtra_pad_d;
    logic                  last_q, last_d;
    logic                  valid_q, valid_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;

    logic [DataWidth-1:0]  padded_word;
    logic                  padded_fit;

    sha2_word_pad #(
        .DataWidth(DataWidth)
    ) u_word_pad (
        .word_i   (in_data_i),
        .bytes_i  (in_bytes_i),
        .word_c   (padded_word),
        .pad_fit_c(padded_fit)
    );

    logic                 in_xfer;
    logic                 out_xfer;
    logic [BytesW-1:0]    word_bytes;
    logic [DataWidth-1:0] word_w;
    int unsigned          pad_pos;

    // Next-state, buffer assembly and length accounting.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        idx_d      = idx_q;
        len_d      = len_q;
        bytes_d    = bytes_q;
        pad_fit_d  = pad_fit_q;
        xtra_d     = xtra_q;
        xtra_pad_d = xtra_pad_q;
        last_d     = last_q;
        in_xfer    = in_valid_i && ready_q;
        out_xfer   = valid_q && block_ready_i;
        word_bytes = in_last_i ? in_bytes_i : BytesW'(DataBytes);
        word_w     = in_last_i ? padded_word : in_data_i;
        pad_pos    = 32'(idx_q) * DataBytes + 32'(bytes_q);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = FILL;
                    buf_d      = '0;
                    idx_d      = '0;
                    len_d      = '0;
                    xtra_d     = 1'b0;
                    xtra_pad_d = 1'b0;
                    last_d     = 1'b0;
                end
            end
            FILL: begin
                if (in_xfer) begin
                    len_d = len_q + (LenWidth'(word_bytes) << 3);
                    for (int i = 0; i < int'(WordsPerBlk); i++) begin
                        if (idx_q == IdxW'(i)) begin
                            buf_d[BlockWidth-1-i*DataWidth -: DataWidth] = word_w;
                        end
                    end
                    if (in_last_i) begin
                        // idx stays on the last word so PAD can locate the pad byte
                        bytes_d   = in_bytes_i;
                        pad_fit_d = padded_fit;
                        state_d   = PAD;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                        if (idx_q == IdxW'(WordsPerBlk - 1)) begin
                            last_d  = 1'b0;
                            state_d = EMIT;
                        end
                    end
                end
            end
            PAD: begin
                state_d = EMIT;
                if (!pad_fit_q && idx_q == IdxW'(WordsPerBlk - 1)) begin
                    // data filled the block exactly: pad byte and length go to an extra block
                    last_d     = 1'b0;
                    xtra_d     = 1'b1;
                    xtra_pad_d = 1'b1;
                end else begin
                    if (!pad_fit_q) begin
                        for (int i = 1; i < int'(WordsPerBlk); i++) begin
                            if (idx_q == IdxW'(i - 1)) begin
                                buf_d[BlockWidth-1-i*DataWidth -: 8] = PAD_BYTE;
                            end
                        end
                    end
                    if (pad_pos + 1 + LenBytes <= BlockBytes) begin
                        buf_d[LenWidth-1:0] = len_q;
                        last_d              = 1'b1;
                    end else begin
                        last_d     = 1'b0;
                        xtra_d     = 1'b1;
                        xtra_pad_d = 1'b0;
                    end
                end
            end
            EMIT: begin
                if (out_xfer) begin
                    if (last_q) begin
                        state_d = IDLE;
                        last_d  = 1'b0;
                    end else if (xtra_q) begin
                        state_d = XTRA;
                    end else begin
                        state_d = FILL;
                        idx_d   = '0;
                        buf_d   = '0;
                    end
                end
            end
            XTRA: begin
                buf_d = '0;
                if (xtra_pad_q) begin
                    buf_d[BlockWidth-1 -: 8] = PAD_BYTE;
                end
                buf_d[LenWidth-1:0] = len_q;
                xtra_d              = 1'b0;
                last_d              = 1'b1;
                state_d             = EMIT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = (state_d == EMIT);
        ready_d = (state_d == FILL);
        busy_d  = (state_d != IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            bytes_q    <= '0;
            pad_fit_q  <= 1'b0;
            xtra_q     <= 1'b0;
            xtra_pad_q <= 1'b0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            bytes_q    <= bytes_d;
            pad_fit_q  <= pad_fit_d;
            xtra_q     <= xtra_d;
            xtra_pad_q <= xtra_pad_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign in_ready_o    = ready_q;
    assign block_o       = buf_q;
    assign block_valid_o = valid_q;
    assign block_last_o  = last_q;
    assign busy_o        = busy_q;

endmodule
